// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one ROM read port between fetch and data read.
// Checks range/alignment, registers the ROM word and pulses a per-port ack.
module rom_arbiter #(
    parameter logic [15:0] BOUND_U = 16'hffff,
    parameter logic [15:0] BOUND_L = 16'hc000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ack,
    output logic [15:0] if_rdata,
    output logic        if_err,
    input  logic        dr_req,
    input  logic [15:0] dr_addr,
    output logic        dr_ack,
    output logic [15:0] dr_rdata,
    output logic        dr_err,
    output logic [15:0] rom_addr,
    input  logic [15:0] rom_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DR = 1'b1;

    state_t      state;
    state_t      nxt;
    logic        owner;
    logic        rr_last;
    logic        valid_q;
    logic [15:0] addr_q;

    logic        any_req;
    logic        sel;
    logic [15:0] sel_addr;
    logic [16:0] addr_ext;
    logic        sel_valid;

    // Pick the winner and check its address; 17 bits keep 16'hffff + 1 from wrapping.
    always_comb begin
        any_req  = if_req | dr_req;
        sel      = PORT_IF;
        if (if_req && dr_req) begin
            sel = ~rr_last;
        end else if (dr_req) begin
            sel = PORT_DR;
        end
        sel_addr  = (sel == PORT_DR) ? dr_addr : if_addr;
        addr_ext  = {1'b0, sel_addr};
        sel_valid = ~sel_addr[0]
                  & (addr_ext >= {1'b0, BOUND_L})
                  & ((addr_ext + 17'd1) <= {1'b0, BOUND_U});
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next-state: a fixed three-cycle walk once a request is taken.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (any_req) nxt = ACCESS;
            ACCESS:  nxt = RESP;
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Datapath: latch the grant, drive the ROM, then return the word with an ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner    <= PORT_IF;
            rr_last  <= PORT_DR;
            valid_q  <= 1'b0;
            addr_q   <= 16'h0000;
            rom_addr <= 16'h0000;
            if_ack   <= 1'b0;
            if_err   <= 1'b0;
            if_rdata <= 16'h0000;
            dr_ack   <= 1'b0;
            dr_err   <= 1'b0;
            dr_rdata <= 16'h0000;
        end else begin
            if_ack <= 1'b0;
            if_err <= 1'b0;
            dr_ack <= 1'b0;
            dr_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner   <= sel;
                        addr_q  <= sel_addr;
                        valid_q <= sel_valid;
                    end
                end
                ACCESS: begin
                    if (valid_q) begin
                        rom_addr <= addr_q - BOUND_L;
                    end
                end
                RESP: begin
                    rr_last <= owner;
                    if (owner == PORT_IF) begin
                        if_ack   <= 1'b1;
                        if_err   <= ~valid_q;
                        if_rdata <= valid_q ? rom_out : 16'h0000;
                    end else begin
                        dr_ack   <= 1'b1;
                        dr_err   <= ~valid_q;
                        dr_rdata <= valid_q ? rom_out : 16'h0000;
                    end
                end
                default: begin
                    rr_last <= rr_last;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: transaction-timeline model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = 16'h0000;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        if_err;
    logic        dr_req = 1'b0;
    logic [15:0] dr_addr = 16'h0000;
    logic        dr_ack;
    logic [15:0] dr_rdata;
    logic        dr_err;
    logic [15:0] rom_addr;
    logic [15:0] rom_out;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    rom_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .if_rdata(if_rdata), .if_err(if_err),
        .dr_req(dr_req), .dr_addr(dr_addr), .dr_ack(dr_ack),
        .dr_rdata(dr_rdata), .dr_err(dr_err),
        .rom_addr(rom_addr), .rom_out(rom_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // ROM contents: word at offset 4 is 16'h1234, everything else a hash.
    function automatic logic [15:0] rom_word(input logic [15:0] off);
        logic [15:0] h;
        h = off * 16'h9e37 + 16'h0001;
        return (off == 16'h0004) ? 16'h1234 : h;
    endfunction

    assign rom_out = rom_word(rom_addr);

    function automatic void chk(input string nm, input logic [15:0] act,
                                input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Model: a granted access occupies cycles g..g+3 (g = cycle the req was taken).
    int          cyc = 0;
    bit          started = 0;
    bit          act = 0;
    int          g = 0;
    bit          m_own;
    bit          m_valid;
    bit          m_rr = 1;
    logic [15:0] m_off;
    logic [15:0] e_if_rdata = 0, e_dr_rdata = 0, e_rom = 0;
    bit          e_if_ack = 0, e_dr_ack = 0, e_if_err = 0, e_dr_err = 0;
    bit          e_busy = 0;

    always @(posedge clk) begin
        int prev;
        int a;
        prev = cyc;
        cyc  = cyc + 1;
        e_if_ack = 0;
        e_dr_ack = 0;
        e_if_err = 0;
        e_dr_err = 0;
        if (rst) begin
            act = 0;
            m_rr = 1;
            e_if_rdata = 0;
            e_dr_rdata = 0;
            e_rom = 0;
            e_busy = 0;
        end else begin
            if ((!act || prev >= g + 3) && (if_req || dr_req)) begin
                m_own   = (if_req && dr_req) ? !m_rr : dr_req;
                a       = m_own ? int'(dr_addr) : int'(if_addr);
                m_valid = (a % 2 == 0) && (a >= 'hc000) && (a + 1 <= 'hffff);
                m_off   = 16'(a - 'hc000);
                g       = prev;
                act     = 1;
            end
            e_busy = act && (cyc == g + 1 || cyc == g + 2);
            if (act && m_valid && cyc == g + 2) e_rom = m_off;
            if (act && cyc == g + 3) begin
                m_rr = m_own;
                if (!m_own) begin
                    e_if_ack   = 1;
                    e_if_err   = !m_valid;
                    e_if_rdata = m_valid ? rom_word(m_off) : 16'h0000;
                end else begin
                    e_dr_ack   = 1;
                    e_dr_err   = !m_valid;
                    e_dr_rdata = m_valid ? rom_word(m_off) : 16'h0000;
                end
            end
        end
        started = 1;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("if_ack", 16'(if_ack), 16'(e_if_ack));
            chk("if_err", 16'(if_err), 16'(e_if_err));
            chk("if_rdata", if_rdata, e_if_rdata);
            chk("dr_ack", 16'(dr_ack), 16'(e_dr_ack));
            chk("dr_err", 16'(dr_err), 16'(e_dr_err));
            chk("dr_rdata", dr_rdata, e_dr_rdata);
            chk("rom_addr", rom_addr, e_rom);
            chk("busy", 16'(busy), 16'(e_busy));
            chk("both_acks", 16'(if_ack & dr_ack), 16'h0000);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for an ack on one port, bounded; returns cycles waited.
    task automatic wait_ack(input bit port, input string nm, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(port ? dr_ack : if_ack) && n < 20);
        chk({nm, "_seen"}, 16'(port ? dr_ack : if_ack), 16'h0001);
    endtask

    // Wait for an ack on either port, bounded; returns which port acked.
    task automatic wait_any(input string nm, output bit port, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(if_ack || dr_ack) && n < 20);
        chk({nm, "_seen"}, 16'(if_ack | dr_ack), 16'h0001);
        port = dr_ack;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int  n;
        bit  p;
        bit  order [4];
        do_reset();
        chk("rst_busy", 16'(busy), 16'h0000);
        chk("rst_rom_addr", rom_addr, 16'h0000);
        chk("rst_if_rdata", if_rdata, 16'h0000);
        chk("rst_dr_rdata", dr_rdata, 16'h0000);

        // Basic fetch at offset 4.
        if_req = 1'b1;
        if_addr = 16'hc004;
        wait_ack(1'b0, "t1_ack", n);
        if_req = 1'b0;
        chk("t1_latency", 16'(n), 16'd3);
        chk("t1_rdata", if_rdata, 16'h1234);
        chk("t1_err", 16'(if_err), 16'h0000);
        chk("t1_rom_addr", rom_addr, 16'h0004);

        // Both held: grants alternate starting with IF after reset.
        do_reset();
        if_req = 1'b1;
        if_addr = 16'hc000;
        dr_req = 1'b1;
        dr_addr = 16'hc010;
        for (int i = 0; i < 4; i++) begin
            wait_any("t2_ack", p, n);
            order[i] = p;
            if (i > 0) chk("t2_spacing", 16'(n), 16'd3);
        end
        if_req = 1'b0;
        dr_req = 1'b0;
        chk("t2_order", {12'h0, order[0], order[1], order[2], order[3]}, 16'h0005);
        chk("t2_dr_rdata", dr_rdata, rom_word(16'h0010));

        // Misaligned read: error, zero data, rom_addr untouched.
        tick();
        dr_req = 1'b1;
        dr_addr = 16'hc003;
        wait_ack(1'b1, "t3_ack", n);
        dr_req = 1'b0;
        chk("t3_err", 16'(dr_err), 16'h0001);
        chk("t3_rdata", dr_rdata, 16'h0000);
        chk("t3_rom_addr", rom_addr, 16'h0010);

        // Range boundaries.
        dr_req = 1'b1;
        dr_addr = 16'hbffe;
        wait_ack(1'b1, "t4a_ack", n);
        chk("t4a_err", 16'(dr_err), 16'h0001);
        dr_addr = 16'hffff;
        wait_ack(1'b1, "t4b_ack", n);
        dr_req = 1'b0;
        chk("t4b_err", 16'(dr_err), 16'h0001);
        if_req = 1'b1;
        if_addr = 16'hfffe;
        wait_ack(1'b0, "t4c_ack", n);
        if_req = 1'b0;
        chk("t4c_err", 16'(if_err), 16'h0000);
        chk("t4c_rom_addr", rom_addr, 16'h3ffe);

        // Reset during ACCESS aborts; the still-pending fetch then completes.
        if_req = 1'b1;
        if_addr = 16'hc008;
        tick();
        chk("t5_busy_access", 16'(busy), 16'h0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy", 16'(busy), 16'h0000);
        chk("t5_rom_addr", rom_addr, 16'h0000);
        chk("t5_no_ack", 16'(if_ack), 16'h0000);
        wait_ack(1'b0, "t5_ack", n);
        if_req = 1'b0;
        chk("t5_latency", 16'(n), 16'd3);
        chk("t5_rom_addr2", rom_addr, 16'h0008);

        // DR granted first, IF arrives a cycle later and waits its turn.
        dr_req = 1'b1;
        dr_addr = 16'hc020;
        tick();
        if_req = 1'b1;
        if_addr = 16'hc030;
        wait_ack(1'b1, "t6_dr_ack", n);
        dr_req = 1'b0;
        chk("t6_dr_latency", 16'(n), 16'd2);
        chk("t6_if_hold", if_rdata, rom_word(16'h0008));
        wait_ack(1'b0, "t6_if_ack", n);
        if_req = 1'b0;
        chk("t6_if_latency", 16'(n), 16'd3);
        chk("t6_if_rdata", if_rdata, rom_word(16'h0030));

        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
